// File: rtl/bounce_generator_pkg.sv
// Shared definitions for the button-bounce emulator.
//   state_e      : FSM state encoding (IDLE..QUIET)
//   LFSR_TAPS    : Galois feedback taps for the 16-bit LFSR
//   DEFAULT_SEED : seed used when the configured seed is zero
//   lfsr_step()  : one Galois shift of the LFSR
package bounce_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HOLD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        QUIET          = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form: the bit shifted out folds the taps back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bounce_generator_if.sv
// Request/status bundle of the bounce emulator.
//   start    : one-cycle request for a press sequence
//   hold_len : stable-high length, captured with an accepted start
//   raw      : emulated button line
//   busy     : sequence in progress
//   done     : one-cycle end-of-sequence pulse
// master drives the request side, slave is the generator.
interface bounce_generator_if;
    logic        start;
    logic [15:0] hold_len;
    logic        raw;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output hold_len,
        input  raw,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hold_len,
        output raw,
        output busy,
        output done
    );
endinterface

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR, shifting every cycle.
//   clk5  : clock
//   reset : synchronous active-high, loads the seed
//   seed  : reset value; zero is replaced by DEFAULT_SEED so the state is never all-zero
//   q     : current LFSR state
module lfsr16
    import bounce_pkg::*;
(
    input  logic        clk5,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk5) begin
        if (reset) begin
            lfsr_q <= seed_eff;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Button-bounce emulator: on start drives raw through a bouncing press, a stable
// hold, a bouncing release and a quiet period, all registered.
//   clk5  : clock
//   reset : synchronous active-high
//   bus   : slave side of bounce_generator_if (start, hold_len in; raw, busy, done out)
module bounce_generator
    import bounce_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned GAP_BITS      = 3,
    parameter int unsigned QUIET_CYCLES  = 16,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input logic               clk5,
    input logic               reset,
    bounce_generator_if.slave bus
);

    localparam int unsigned WIN_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int unsigned Q_W   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [Q_W-1:0]   Q_LOAD   = Q_W'(QUIET_CYCLES - 1);

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]         hold_cnt_q, hold_cnt_d;
    logic [Q_W-1:0]      q_cnt_q, q_cnt_d;
    logic [15:0]         hold_q, hold_d;
    logic                raw_q, raw_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [15:0]         lfsr;
    logic [GAP_BITS-1:0] gap_seed;

    lfsr16 u_lfsr (
        .clk5  (clk5),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr)
    );

    assign gap_seed = lfsr[GAP_BITS-1:0];

    // Only the low GAP_BITS of the LFSR shape the gaps.
    if (GAP_BITS < 16) begin : g_unused_lfsr
        logic unused_lfsr_bits;
        assign unused_lfsr_bits = ^lfsr[15:GAP_BITS];
    end

    // State, counter and output registers.
    always_ff @(posedge clk5) begin
        if (reset) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            hold_cnt_q <= '0;
            q_cnt_q    <= '0;
            hold_q     <= '0;
            raw_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            q_cnt_q    <= q_cnt_d;
            hold_q     <= hold_d;
            raw_q      <= raw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:           if (bus.start) state_d = PRESS_BOUNCE;
            PRESS_BOUNCE:   if (win_cnt_q == '0) state_d = HOLD;
            HOLD:           if (hold_cnt_q == '0) state_d = RELEASE_BOUNCE;
            RELEASE_BOUNCE: if (win_cnt_q == '0) state_d = QUIET;
            QUIET:          if (q_cnt_q == '0) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Counters and registered outputs.
    always_comb begin
        win_cnt_d  = win_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        q_cnt_d    = q_cnt_q;
        hold_d     = hold_q;
        raw_d      = raw_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == QUIET) && (state_d == IDLE);

        unique case (state_q)
            IDLE: begin
                raw_d = 1'b0;
                if (bus.start) begin
                    hold_d    = (bus.hold_len == 16'd0) ? 16'd1 : bus.hold_len;
                    win_cnt_d = WIN_LOAD;
                    gap_cnt_d = gap_seed;
                    raw_d     = 1'b1;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (win_cnt_q == '0) begin
                    // Window over: force the settled level of the next phase.
                    if (state_q == PRESS_BOUNCE) begin
                        raw_d      = 1'b1;
                        hold_cnt_d = hold_q - 16'd1;
                    end else begin
                        raw_d   = 1'b0;
                        q_cnt_d = Q_LOAD;
                    end
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                    if (gap_cnt_q == '0) begin
                        raw_d     = ~raw_q;
                        gap_cnt_d = gap_seed;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                raw_d = 1'b1;
                if (hold_cnt_q == '0) begin
                    raw_d     = 1'b0;
                    win_cnt_d = WIN_LOAD;
                    gap_cnt_d = gap_seed;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            QUIET: begin
                raw_d = 1'b0;
                if (q_cnt_q != '0) q_cnt_d = q_cnt_q - 1'b1;
            end
            default: begin
                raw_d = 1'b0;
            end
        endcase
    end

    assign bus.raw  = raw_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
